// File: rtl/usb_pkg.sv
`default_nettype none
// usb_pkg: shared USB host packet type, PID/address constants and scheduler state encoding.
package usb_pkg;

   localparam logic [3:0] PID_OUT  = 4'b0001;
   localparam logic [3:0] PID_IN   = 4'b1001;
   localparam logic [3:0] PID_DATA = 4'b0011;
   localparam logic [3:0] PID_ACK  = 4'b0010;
   localparam logic [3:0] PID_NAK  = 4'b1010;

   localparam logic [6:0] DEV_ADDR = 7'd5;
   localparam logic [3:0] DEV_ENDP = 4'd4;

   typedef struct packed {
      logic [3:0]  pid;
      logic [6:0]  addr;
      logic [3:0]  endp;
      logic [63:0] data;
   } pkt_t;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_LAUNCH   = 2'd1,
      S_WAIT     = 2'd2,
      S_COMPLETE = 2'd3
   } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// rr_arbiter: combinational round-robin pick; the search starts at ptr and wraps modulo NUM_REQ.
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] idx
);

   localparam int IW = $clog2(NUM_REQ);

   // One extra bit so ptr+k never overflows before the modulo fold.
   logic [IW:0]   sum;
   logic [IW-1:0] cand;
   logic          found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, ptr} + (IW+1)'(k);
         if (sum >= (IW+1)'(NUM_REQ)) begin
            sum = sum - (IW+1)'(NUM_REQ);
         end
         cand = sum[IW-1:0];
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/usb_trans_sched.sv
`default_nettype none
// usb_trans_sched: round-robin IN/OUT transaction scheduler in front of the protocol FSM.
// Relaunch-on-failure is built only when USB_SCHED_RETRY_EN is defined.
module usb_trans_sched
   import usb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int MAX_RETRY = 2
) (
   input  logic                  clk,
   input  logic                  rst_b,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ-1:0]    req_dir,
   input  logic [64*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]    done,
   output logic                  fail,
   output logic [63:0]           rd_data,
   output logic                  busy,
   output logic                  in_trans,
   output logic                  out_trans,
   output logic [63:0]           data_from_host,
   input  logic                  success,
   input  logic                  failure,
   input  logic [63:0]           data_to_host
);

   localparam int IW = $clog2(NUM_REQ);

   sched_state_t       state, state_nx;
   logic [IW-1:0]      ptr, ptr_nx;
   logic [IW-1:0]      idx, idx_nx;
   logic               dir, dir_nx;
   logic [63:0]        dfh_nx, rd_nx;
   logic [NUM_REQ-1:0] done_nx;
   logic               fail_nx, busy_nx, in_nx, out_nx;
   logic [NUM_REQ-1:0] grant;
   logic [IW-1:0]      grant_idx;
   logic               relaunch;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req   (req),
      .ptr   (ptr),
      .grant (grant),
      .idx   (grant_idx)
   );

`ifdef USB_SCHED_RETRY_EN
   localparam int             RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RW-1:0]  RETRY_LIM = RW'(MAX_RETRY);

   logic [RW-1:0] retry_cnt, retry_nx;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         retry_cnt <= '0;
      end else begin
         retry_cnt <= retry_nx;
      end
   end

   always_comb begin
      relaunch = (retry_cnt < RETRY_LIM);
      retry_nx = retry_cnt;
      if (state == S_WAIT && !success && failure && relaunch) begin
         retry_nx = retry_cnt + RW'(1);
      end else if (state == S_COMPLETE) begin
         retry_nx = '0;
      end
   end
`else
   logic unused_max_retry;
   assign unused_max_retry = ^MAX_RETRY;
   assign relaunch         = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      idx_nx   = idx;
      dir_nx   = dir;
      dfh_nx   = data_from_host;
      rd_nx    = rd_data;
      fail_nx  = 1'b0;
      case (state)
         S_IDLE: begin
            if (|grant) begin
               idx_nx   = grant_idx;
               dir_nx   = req_dir[grant_idx];
               dfh_nx   = req_data[{grant_idx, 6'd0} +: 64];
               state_nx = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            state_nx = S_WAIT;
         end
         S_WAIT: begin
            // success has priority when both completions arrive together
            if (success) begin
               state_nx = S_COMPLETE;
               if (dir) begin
                  rd_nx = data_to_host;
               end
            end else if (failure) begin
               if (relaunch) begin
                  state_nx = S_LAUNCH;
               end else begin
                  state_nx = S_COMPLETE;
                  fail_nx  = 1'b1;
               end
            end
         end
         S_COMPLETE: begin
            ptr_nx   = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase

      // Outputs are registered, so they are decoded from the state being entered.
      busy_nx = (state_nx != S_IDLE);
      in_nx   = (state_nx == S_LAUNCH) && dir_nx;
      out_nx  = (state_nx == S_LAUNCH) && !dir_nx;
      done_nx = (state_nx == S_COMPLETE) ? (NUM_REQ'(1) << idx_nx) : '0;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state          <= S_IDLE;
         ptr            <= '0;
         idx            <= '0;
         dir            <= 1'b0;
         data_from_host <= '0;
         rd_data        <= '0;
         done           <= '0;
         fail           <= 1'b0;
         busy           <= 1'b0;
         in_trans       <= 1'b0;
         out_trans      <= 1'b0;
      end else begin
         state          <= state_nx;
         ptr            <= ptr_nx;
         idx            <= idx_nx;
         dir            <= dir_nx;
         data_from_host <= dfh_nx;
         rd_data        <= rd_nx;
         done           <= done_nx;
         fail           <= fail_nx;
         busy           <= busy_nx;
         in_trans       <= in_nx;
         out_trans      <= out_nx;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_usb_trans_sched.sv
`default_nettype none
// tb_usb_trans_sched: directed and randomized traffic checked every cycle against a
// transaction-level model of the scheduler (grant order, strobes, done/fail, data registers).
module tb_usb_trans_sched;

   localparam int N         = 4;
   localparam int MAX_RETRY = 2;
`ifdef USB_SCHED_RETRY_EN
   localparam int RETRIES   = MAX_RETRY;
`else
   localparam int RETRIES   = 0;
`endif

   logic            clk          = 1'b0;
   logic            rst_b        = 1'b0;
   logic [N-1:0]    req          = '0;
   logic [N-1:0]    req_dir      = '0;
   logic [64*N-1:0] req_data     = '0;
   logic            success      = 1'b0;
   logic            failure      = 1'b0;
   logic [63:0]     data_to_host = '0;
   logic [N-1:0]    done;
   logic            fail;
   logic [63:0]     rd_data;
   logic            busy;
   logic            in_trans;
   logic            out_trans;
   logic [63:0]     data_from_host;

   usb_trans_sched #(
      .NUM_REQ   (N),
      .MAX_RETRY (MAX_RETRY)
   ) dut (
      .clk            (clk),
      .rst_b          (rst_b),
      .req            (req),
      .req_dir        (req_dir),
      .req_data       (req_data),
      .done           (done),
      .fail           (fail),
      .rd_data        (rd_data),
      .busy           (busy),
      .in_trans       (in_trans),
      .out_trans      (out_trans),
      .data_from_host (data_from_host),
      .success        (success),
      .failure        (failure),
      .data_to_host   (data_to_host)
   );

   always #5 clk = ~clk;

   // Model state: expected outputs for the current cycle plus scheduler bookkeeping.
   logic         exp_busy = 1'b0, exp_in = 1'b0, exp_out = 1'b0, exp_fail = 1'b0;
   logic [N-1:0] exp_done = '0;
   logic [63:0]  m_rd = '0, m_dfh = '0;
   int           m_ptr = 0;
   bit           quiet = 1'b1;

   int           n_chk = 0, n_err = 0, cyc = 0;
   int           strobe_cnt = 0, strobe_cyc = 0, done_cyc = 0;
   logic         last_fail = 1'b0, last_in = 1'b0;
   logic [N-1:0] last_done = '0;
   int           done_q[$];
   string        lit_nm[$];
   logic [63:0]  lit_act[$];
   logic [63:0]  lit_exp[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      chk("busy",           64'(busy),      64'(exp_busy));
      chk("in_trans",       64'(in_trans),  64'(exp_in));
      chk("out_trans",      64'(out_trans), 64'(exp_out));
      chk("done",           64'(done),      64'(exp_done));
      chk("fail",           64'(fail),      64'(exp_fail));
      chk("rd_data",        rd_data,        m_rd);
      chk("data_from_host", data_from_host, m_dfh);
      if (in_trans || out_trans) begin
         strobe_cnt++;
         strobe_cyc = cyc;
         last_in    = in_trans;
      end
      if (done != '0) begin
         for (int i = 0; i < N; i++) if (done[i]) done_q.push_back(i);
         done_cyc  = cyc;
         last_done = done;
         last_fail = fail;
      end
      while (lit_nm.size() > 0) chk(lit_nm.pop_front(), lit_act.pop_front(), lit_exp.pop_front());
   end

   task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] exp);
      lit_nm.push_back(nm);
      lit_act.push_back(act);
      lit_exp.push_back(exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_exp(input logic b, input logic i, input logic o,
                          input logic [N-1:0] d, input logic f);
      exp_busy = b; exp_in = i; exp_out = o; exp_done = d; exp_fail = f;
   endtask

   // Round-robin rule: first asserted requester at or after ptr, wrapping.
   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic new_req(input int i);
      req[i]               = 1'b1;
      req_dir[i]           = 1'($urandom_range(0, 1));
      req_data[64*i +: 64] = {$urandom, $urandom};
   endtask

   task automatic arrivals();
      if (!quiet) for (int i = 0; i < N; i++) if (!req[i] && $urandom_range(0, 2) == 0) new_req(i);
   endtask

   // Noise during WAIT: new arrivals, edits to latched requests, granted requester dropping req.
   task automatic mutate(input int g);
      data_to_host = {$urandom, $urandom};
      if (quiet) return;
      arrivals();
      if ($urandom_range(0, 3) == 0) begin
         req_dir[g]           = ~req_dir[g];
         req_data[64*g +: 64] = {$urandom, $urandom};
      end
      if ($urandom_range(0, 7) == 0) req[g] = 1'b0;
   endtask

   // Starts in an IDLE cycle with a pending request; returns in the COMPLETE cycle.
   task automatic serve(input int w_fix, input int n_fail, input bit rnd,
                        input logic [63:0] dth_fix, input bit dth_use, output int g);
      logic        mdir;
      logic [63:0] d, dth;
      int          att, w;
      bit          fnow, fin;
      g    = pick(req, m_ptr);
      mdir = req_dir[g];
      d    = req_data[64*g +: 64];
      tick();
      m_dfh = d;
      set_exp(1'b1, mdir, !mdir, '0, 1'b0);
      att = 0;
      fin = 1'b0;
      while (!fin) begin
         tick();
         set_exp(1'b1, 1'b0, 1'b0, '0, 1'b0);
         w = rnd ? int'($urandom_range(0, 3)) : w_fix;
         for (int j = 0; j < w; j++) begin
            mutate(g);
            tick();
         end
         fnow         = (att < n_fail);
         dth          = dth_use ? dth_fix : {$urandom, $urandom};
         data_to_host = dth;
         success      = !fnow;
         failure      = fnow || (rnd && $urandom_range(0, 3) == 0);
         tick();
         success = 1'b0;
         failure = 1'b0;
         if (fnow && att < RETRIES) begin
            att++;
            set_exp(1'b1, mdir, !mdir, '0, 1'b0);
         end else begin
            if (!fnow && mdir) m_rd = dth;
            set_exp(1'b1, 1'b0, 1'b0, N'(1) << g, fnow);
            m_ptr = (g + 1) % N;
            fin   = 1'b1;
         end
      end
   endtask

   task automatic finish_txn(input int g, input bit keep);
      if (keep) new_req(g);
      else req[g] = 1'b0;
      tick();
      set_exp(1'b0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int g, s0, q0, rel;
      int rr_exp[5];
      rr_exp = '{0, 1, 2, 3, 0};

      repeat (3) tick();
      rst_b = 1'b1;

      // Round-robin with all four requesting and immediate success.
      for (int i = 0; i < N; i++) new_req(i);
      q0 = done_q.size();
      for (int k = 0; k < 8; k++) begin
         serve(0, 0, 1'b0, '0, 1'b0, g);
         finish_txn(g, k < 4);
      end
      for (int k = 0; k < 5; k++) lit($sformatf("rr_order%0d", k), 64'(done_q[q0+k]), 64'(rr_exp[k]));

      // Single OUT, success 20 cycles after the strobe.
      req[1] = 1'b1; req_dir[1] = 1'b0; req_data[64*1 +: 64] = 64'hDEAD_BEEF_0123_4567;
      serve(19, 0, 1'b0, '0, 1'b0, g);
      finish_txn(g, 1'b0);
      lit("out_done",    64'(last_done), 64'h2);
      lit("out_fail",    64'(last_fail), 64'h0);
      lit("out_is_out",  64'(last_in),   64'h0);
      lit("out_latency", 64'(done_cyc - strobe_cyc), 64'd21);
      lit("out_dfh",     data_from_host, 64'hDEAD_BEEF_0123_4567);

      // Single IN, then an OUT that must not touch rd_data.
      req[2] = 1'b1; req_dir[2] = 1'b1; req_data[64*2 +: 64] = 64'h1111;
      serve(2, 0, 1'b0, 64'hA5A5_0000_FFFF_1234, 1'b1, g);
      finish_txn(g, 1'b0);
      lit("in_done", 64'(last_done), 64'h4);
      lit("in_fail", 64'(last_fail), 64'h0);
      lit("in_rd",   rd_data,        64'hA5A5_0000_FFFF_1234);
      req[0] = 1'b1; req_dir[0] = 1'b0; req_data[63:0] = 64'h2222;
      serve(1, 0, 1'b0, 64'h3333, 1'b1, g);
      finish_txn(g, 1'b0);
      lit("rd_after_out", rd_data, 64'hA5A5_0000_FFFF_1234);

      // Failure on every attempt, then failure only on the first.
      req[3] = 1'b1; req_dir[3] = 1'b0;
      s0 = strobe_cnt;
      serve(1, 100, 1'b0, '0, 1'b0, g);
      finish_txn(g, 1'b0);
`ifdef USB_SCHED_RETRY_EN
      lit("allfail_strobes", 64'(strobe_cnt - s0), 64'd3);
`else
      lit("allfail_strobes", 64'(strobe_cnt - s0), 64'd1);
`endif
      lit("allfail_fail", 64'(last_fail), 64'h1);
      req[0] = 1'b1; req_dir[0] = 1'b1;
      s0 = strobe_cnt;
      serve(1, 1, 1'b0, '0, 1'b0, g);
      finish_txn(g, 1'b0);
`ifdef USB_SCHED_RETRY_EN
      lit("fail1_strobes", 64'(strobe_cnt - s0), 64'd2);
      lit("fail1_fail",    64'(last_fail),       64'h0);
`else
      lit("fail1_strobes", 64'(strobe_cnt - s0), 64'd1);
      lit("fail1_fail",    64'(last_fail),       64'h1);
`endif

      // Randomized traffic.
      quiet = 1'b0;
      for (int t = 0; t < 250; t++) begin
         arrivals();
         if (pick(req, m_ptr) < 0) begin
            tick();
            set_exp(1'b0, 1'b0, 1'b0, '0, 1'b0);
         end else begin
            serve(0, int'($urandom_range(0, 4)), 1'b1, '0, 1'b0, g);
            finish_txn(g, 1'($urandom_range(0, 1)));
         end
      end

      // Drain, then reset in the middle of a WAIT.
      quiet = 1'b1;
      for (int k = 0; k < N && pick(req, m_ptr) >= 0; k++) begin
         serve(0, 0, 1'b0, '0, 1'b0, g);
         finish_txn(g, 1'b0);
      end
      req[2] = 1'b1; req_dir[2] = 1'b1; req_data[64*2 +: 64] = 64'h4444;
      tick();
      m_dfh = 64'h4444;
      set_exp(1'b1, 1'b1, 1'b0, '0, 1'b0);
      tick();
      set_exp(1'b1, 1'b0, 1'b0, '0, 1'b0);
      tick();
      rst_b = 1'b0;
      m_dfh = '0; m_rd = '0; m_ptr = 0;
      set_exp(1'b0, 1'b0, 1'b0, '0, 1'b0);
      req = 4'b1000; req_dir[3] = 1'b0; req_data[64*3 +: 64] = 64'h5555;
      q0 = done_q.size();
      tick();
      tick();
      rst_b = 1'b1;
      rel   = cyc + 1;
      serve(1, 0, 1'b0, '0, 1'b0, g);
      finish_txn(g, 1'b0);
      lit("rst_no_done",      64'(done_q.size() - q0), 64'd1);
      lit("rst_grant",        64'(last_done),          64'h8);
      lit("rst_strobe_delay", 64'(strobe_cyc - rel),   64'd1);

      tick();
      tick();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/usb_trans_sched.md
# usb_trans_sched

Host-side transaction scheduler in front of `protocolFSM`. It collects IN and OUT transaction requests from NUM_REQ independent requesters and arbitrates among them round-robin. It launches one transaction at a time on the protocol FSM's `in_trans`/`out_trans` strobes and holds the OUT payload stable until the transaction ends. It then returns the completion status and IN data to the granted requester.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..8.
- MAX_RETRY, 2: extra launches after a `failure`; active only with USB_SCHED_RETRY_EN.

Ports:
- clk  in  1  clock
- rst_b  in  1  reset: asynchronous, active-low
- req  in  NUM_REQ  requester i wants a transaction; held high until `done[i]`
- req_dir  in  NUM_REQ  1 = IN (device to host), 0 = OUT
- req_data  in  64*NUM_REQ  OUT payload for requester i at [64*i +: 64]
- done  out  NUM_REQ  one-cycle completion pulse, one-hot
- fail  out  1  valid with done; 1 = transaction failed
- rd_data  out  64  IN data from the last successful IN transaction
- busy  out  1  high in every state except IDLE
- in_trans  out  1  one-cycle strobe to the protocol FSM
- out_trans  out  1  one-cycle strobe to the protocol FSM
- data_from_host  out  64  latched OUT payload
- success  in  1  protocol FSM completion, ok
- failure  in  1  protocol FSM completion, failed
- data_to_host  in  64  IN payload, valid with `success`

## Operation
- State machine: IDLE, LAUNCH, WAIT, COMPLETE.
- IDLE
  - Round-robin select among asserted `req`, starting search at `ptr`.
  - On a hit, latch `idx`, `dir` = `req_dir[idx]` and `data_from_host` = `req_data[idx]`; go to LAUNCH.
  - With no request, stay in IDLE.
- LAUNCH
  - `in_trans` (dir = 1) or `out_trans` (dir = 0) is high for exactly this cycle.
  - Always go to WAIT next.
- WAIT
  - Stay until `success` or `failure`. No internal timeout; the protocol FSM bounds the wait.
  - On `success`: go to COMPLETE with fail = 0. If dir = IN, capture `data_to_host` into `rd_data`.
  - On `failure`: with retry enabled and `retry_cnt < MAX_RETRY`, increment `retry_cnt` and go to LAUNCH. Otherwise go to COMPLETE with fail = 1.
  - If `success` and `failure` are both high, `success` wins.
- COMPLETE
  - `done[idx]` = 1 and `fail` valid for this single cycle.
  - Set `ptr` to (idx+1) mod NUM_REQ and clear `retry_cnt`; go to IDLE.
- `data_from_host` is held constant from LAUNCH through COMPLETE, because the protocol FSM resamples it on every resend.
- `req[idx]` dropping mid-transaction is ignored: the transaction completes and `done` still pulses.
- `req_dir`/`req_data` changes after the IDLE latch are ignored.
- `rd_data` holds its value until the next successful IN transaction. OUT transactions never modify it.
- `retry_cnt` width is $clog2(MAX_RETRY+1).

## Timing
- Reset values: state IDLE, ptr = 0, retry_cnt = 0. All outputs are 0, including `rd_data` and `data_from_host`.
- All outputs are registered.
- Start of a transaction: `req` sampled high in IDLE at cycle 0 → `in_trans`/`out_trans` high at cycle 1.
- End of a transaction: `success`/`failure` at cycle k → `done` at k+1 → IDLE at k+2 → earliest next strobe at k+3. The protocol FSM is back in Hold by then.
- Retry: `failure` at k → strobe at k+1; the protocol FSM is already in Hold at k+1.
- A requester keeping `req` high after `done` is re-arbitrated, with the lowest priority for that pass.
- rst_b asserted mid-transaction forces IDLE and zeroes outputs immediately. No `done` is issued for the aborted transaction. The protocol FSM shares the same reset.

## Configuration
- USB_SCHED_RETRY_EN defined: on `failure`, the scheduler relaunches up to MAX_RETRY times before reporting fail = 1. Worst case is MAX_RETRY+1 strobes per transaction.
- USB_SCHED_RETRY_EN undefined: `retry_cnt` is not built, and any `failure` goes directly to COMPLETE with fail = 1.

## Structure
- Shared package `usb_pkg` holds:
  - `pkt_t`
  - PID constants: OUT 4'b0001, IN 4'b1001, DATA 4'b0011, ACK 4'b0010, NAK 4'b1010
  - device address 7'd5 and endpoint 4'd4
  - the `sched_state_t` enum
- Sub-module `rr_arbiter` #(NUM_REQ): combinational; inputs `req` and `ptr`, outputs a one-hot grant and the encoded index.

## Test plan
- Single OUT: req[1] = 1, req_dir[1] = 0, req_data[1] = 64'hDEAD_BEEF_0123_4567, success 20 cycles after the strobe → `out_trans` at cycle 1, `data_from_host` = that value, done = 4'b0010, fail = 0 one cycle after `success`.
- Single IN: req[2] IN, `data_to_host` = 64'hA5A5_0000_FFFF_1234 with `success` → rd_data = that value, done = 4'b0100, fail = 0; a following OUT leaves rd_data unchanged.
- Round-robin: req = 4'b1111 held continuously with immediate success → done order 0, 1, 2, 3, 0; no requester is granted twice before all others.
- Retry (USB_SCHED_RETRY_EN, MAX_RETRY = 2): `failure` on every attempt → exactly 3 strobes, then done with fail = 1. Success on the second attempt → 2 strobes, fail = 0.
- No retry (macro undefined): one `failure` → done with fail = 1 one cycle later, one strobe total.
- Reset mid-WAIT: rst_b low while busy → all outputs 0, no done pulse. After release, a pending req[3] gives a strobe 1 cycle after its IDLE sample, granting requester 3 (ptr = 0).
